// File: rtl/seg7_stream_monitor.sv
// Recovers the displayed digit from an active-low 7-segment bus, filters glitches, infers count direction and step period.
// Optional SEG7_BLANK_EN: all-off pattern 7F is a legal blank that returns the monitor to IDLE.
module seg7_stream_monitor #(
   parameter int STABLE_CYC = 4,
   parameter int PW         = 26,
   parameter int MOD        = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [6:0]    seg_in,
   output logic [3:0]    digit,
   output logic          digit_vld,
   output logic          step_pulse,
   output logic          dir_up,
   output logic          dir_vld,
   output logic          seq_err,
   output logic          bad_pat,
   output logic [PW-1:0] period,
   output logic          period_vld
);

   typedef enum logic [1:0] {IDLE, LOCKED, TRACKING} state_t;

   localparam logic [7:0] STAB   = 8'(STABLE_CYC);
   localparam logic [3:0] MOD_L  = 4'(MOD);
   localparam logic [3:0] MOD_M1 = 4'(MOD - 1);

   // Returns {legal, digit}; codes for digits at or above MOD are illegal.
   function automatic logic [4:0] decode(input logic [6:0] code);
      logic [3:0] d;
      logic       hit;
      hit = 1'b1;
      d   = 4'd0;
      case (code)
         7'h40: d = 4'd0;
         7'h79: d = 4'd1;
         7'h24: d = 4'd2;
         7'h30: d = 4'd3;
         7'h19: d = 4'd4;
         7'h12: d = 4'd5;
         7'h02: d = 4'd6;
         7'h78: d = 4'd7;
         7'h00: d = 4'd8;
         7'h10: d = 4'd9;
         default: hit = 1'b0;
      endcase
      return {hit && (d < MOD_L), d};
   endfunction

   state_t        state_q, state_d;
   logic [6:0]    samp_q, acc_q;
   logic [7:0]    stab_q;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [3:0]    digit_d;
   logic          dvld_d, step_d, up_d, dirv_d, err_d, bad_d, pvld_d;
   logic [PW-1:0] per_d;

   logic          accept, legal, blank;
   logic [3:0]    dnew, up_step, dn_step;

   always_comb begin
      accept  = (stab_q == STAB) && (samp_q != acc_q);
      {legal, dnew} = decode(samp_q);
`ifdef SEG7_BLANK_EN
      blank   = (samp_q == 7'h7F);
`else
      blank   = 1'b0;
`endif
      up_step = (digit == MOD_M1) ? 4'd0 : digit + 4'd1;
      dn_step = (digit == 4'd0) ? MOD_M1 : digit - 4'd1;

      state_d = state_q;
      digit_d = digit;
      dvld_d  = digit_vld;
      step_d  = 1'b0;
      up_d    = dir_up;
      dirv_d  = dir_vld;
      err_d   = 1'b0;
      bad_d   = bad_pat;
      per_d   = period;
      pvld_d  = period_vld;
      cnt_d   = (state_q != IDLE && cnt_q != '1) ? cnt_q + PW'(1) : cnt_q;

      if (accept) begin
         if (blank) begin
            state_d = IDLE;
            dvld_d  = 1'b0;
            dirv_d  = 1'b0;
            pvld_d  = 1'b0;
            bad_d   = 1'b0;
            cnt_d   = '0;
         end else if (!legal) begin
            bad_d = 1'b1;
         end else begin
            bad_d   = 1'b0;
            digit_d = dnew;
            dvld_d  = 1'b1;
            step_d  = 1'b1;
            cnt_d   = PW'(1);
            if (state_q == IDLE) begin
               state_d = LOCKED;
            end else begin
               state_d = TRACKING;
               per_d   = cnt_q;
               pvld_d  = 1'b1;
               // Up is tested first so MOD=2 resolves the +1/-1 tie as up.
               if (dnew == up_step) begin
                  up_d   = 1'b1;
                  dirv_d = 1'b1;
               end else if (dnew == dn_step) begin
                  up_d   = 1'b0;
                  dirv_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         samp_q     <= 7'h7F;
         acc_q      <= 7'h7F;
         stab_q     <= 8'd0;
         cnt_q      <= '0;
         digit      <= 4'd0;
         digit_vld  <= 1'b0;
         step_pulse <= 1'b0;
         dir_up     <= 1'b0;
         dir_vld    <= 1'b0;
         seq_err    <= 1'b0;
         bad_pat    <= 1'b0;
         period     <= '0;
         period_vld <= 1'b0;
      end else begin
         samp_q <= seg_in;
         if (seg_in == samp_q) begin
            if (stab_q != STAB) stab_q <= stab_q + 8'd1;
         end else begin
            stab_q <= 8'd1;
         end
         if (accept) acc_q <= samp_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         digit      <= digit_d;
         digit_vld  <= dvld_d;
         step_pulse <= step_d;
         dir_up     <= up_d;
         dir_vld    <= dirv_d;
         seq_err    <= err_d;
         bad_pat    <= bad_d;
         period     <= per_d;
         period_vld <= pvld_d;
      end
   end

endmodule

// File: tb/tb_seg7_stream_monitor.sv
// Directed table of held segment codes with hand-computed outputs, plus reset and latency sequences.
module tb_seg7_stream_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  digit;
   logic        digit_vld, step_pulse, dir_up, dir_vld, seq_err, bad_pat, period_vld;
   logic [25:0] period;

   int n_cmp = 0;
   int n_bad = 0;

   seg7_stream_monitor #(.STABLE_CYC(4), .PW(26), .MOD(10)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in),
      .digit(digit), .digit_vld(digit_vld), .step_pulse(step_pulse),
      .dir_up(dir_up), .dir_vld(dir_vld), .seq_err(seq_err),
      .bad_pat(bad_pat), .period(period), .period_vld(period_vld)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  seg;
      int          hold;
      logic [3:0]  dig;
      logic        dvld;
      logic        up;
      logic        dirv;
      logic        bad;
      logic [25:0] per;
      logic        pvld;
      int          steps;
      int          errs;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int steps, errs;
      //            seg    hold dig v  up dv bad per  pv st er
      tbl[0]  = '{7'h40, 100, 4'd0, 1, 0, 0, 0, 26'd0,   0, 1, 0};
      tbl[1]  = '{7'h79, 100, 4'd1, 1, 1, 1, 0, 26'd100, 1, 1, 0};
      tbl[2]  = '{7'h24, 100, 4'd2, 1, 1, 1, 0, 26'd100, 1, 1, 0};
      tbl[3]  = '{7'h79,  60, 4'd1, 1, 0, 1, 0, 26'd100, 1, 1, 0};
      tbl[4]  = '{7'h40,  37, 4'd0, 1, 0, 1, 0, 26'd60,  1, 1, 0};
      tbl[5]  = '{7'h10,  50, 4'd9, 1, 0, 1, 0, 26'd37,  1, 1, 0};
      tbl[6]  = '{7'h40,  25, 4'd0, 1, 1, 1, 0, 26'd50,  1, 1, 0};
      tbl[7]  = '{7'h79,  40, 4'd1, 1, 1, 1, 0, 26'd25,  1, 1, 0};
      tbl[8]  = '{7'h24,   3, 4'd1, 1, 1, 1, 0, 26'd25,  1, 0, 0};
      tbl[9]  = '{7'h79,  40, 4'd1, 1, 1, 1, 0, 26'd25,  1, 0, 0};
      tbl[10] = '{7'h12,  30, 4'd5, 1, 1, 1, 0, 26'd83,  1, 1, 1};
`ifdef SEG7_BLANK_EN
      tbl[11] = '{7'h7F,  20, 4'd5, 0, 1, 0, 0, 26'd83,  0, 0, 0};
      tbl[12] = '{7'h02,  40, 4'd6, 1, 1, 0, 0, 26'd83,  0, 1, 0};
`else
      tbl[11] = '{7'h7F,  20, 4'd5, 1, 1, 1, 1, 26'd83,  1, 0, 0};
      tbl[12] = '{7'h02,  40, 4'd6, 1, 1, 1, 0, 26'd50,  1, 1, 0};
`endif
      tbl[13] = '{7'h78,  30, 4'd7, 1, 1, 1, 0, 26'd40,  1, 1, 0};

      rst    = 1'b1;
      seg_in = 7'h7F;
      repeat (3) tick();
      rst = 1'b0;
      repeat (8) tick();
      chk("reset digit", digit, 0);
      chk("reset digit_vld", digit_vld, 0);
      chk("reset step_pulse", step_pulse, 0);
      chk("reset dir_vld", dir_vld, 0);
      chk("reset bad_pat", bad_pat, 0);
      chk("reset period_vld", period_vld, 0);

      for (int i = 0; i < 14; i++) begin
         seg_in = tbl[i].seg;
         steps  = 0;
         errs   = 0;
         for (int c = 0; c < tbl[i].hold; c++) begin
            tick();
            steps += int'(step_pulse);
            errs  += int'(seq_err);
         end
         chk($sformatf("v%0d digit", i), digit, tbl[i].dig);
         chk($sformatf("v%0d digit_vld", i), digit_vld, tbl[i].dvld);
         chk($sformatf("v%0d dir_up", i), dir_up, tbl[i].up);
         chk($sformatf("v%0d dir_vld", i), dir_vld, tbl[i].dirv);
         chk($sformatf("v%0d bad_pat", i), bad_pat, tbl[i].bad);
         chk($sformatf("v%0d period", i), period, tbl[i].per);
         chk($sformatf("v%0d period_vld", i), period_vld, tbl[i].pvld);
         chk($sformatf("v%0d step_pulses", i), steps, tbl[i].steps);
         chk($sformatf("v%0d seq_errs", i), errs, tbl[i].errs);
      end

      // Reset while tracking discards all history.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst digit", digit, 0);
      chk("midrst digit_vld", digit_vld, 0);
      chk("midrst dir_up", dir_up, 0);
      chk("midrst dir_vld", dir_vld, 0);
      chk("midrst period", period, 0);
      chk("midrst period_vld", period_vld, 0);

      // seg_in still 78: first acceptance lands exactly on the 5th edge.
      steps = 0;
      repeat (4) begin
         tick();
         steps += int'(step_pulse);
      end
      chk("lat early pulses", steps, 0);
      chk("lat early digit_vld", digit_vld, 0);
      tick();
      chk("lat step_pulse", step_pulse, 1);
      chk("lat digit", digit, 7);
      chk("lat digit_vld", digit_vld, 1);
      chk("lat dir_vld", dir_vld, 0);
      chk("lat period_vld", period_vld, 0);
      tick();
      chk("lat pulse width", step_pulse, 0);

      // Reset coinciding with an acceptance wins.
      seg_in = 7'h40;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstwin digit_vld", digit_vld, 0);
      chk("rstwin step_pulse", step_pulse, 0);
      chk("rstwin digit", digit, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_stream_monitor.md
Name: seg7_stream_monitor

Overview:
- Receive side of the 7-segment display path: samples one digit's segment bus (the same encoding the pattern/counter drivers emit) and recovers the displayed digit 0-9.
- Filters glitches, infers count direction (up/down, with wrap), and measures the step period in clock cycles.
- Used on-board as a self-check of the display drivers and as a digit reader for the simulation bench.

Parameters:
- STABLE_CYC, 4, consecutive identical samples required before a pattern is accepted (1..255).
- PW, 26, period counter / period output width.
- MOD, 10, digit modulus for wrap detection (2..10); digits >= MOD count as invalid.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- seg_in  input  7  segment bus, active-low, bit order {g,f,e,d,c,b,a}
- digit  output  4  last accepted valid digit
- digit_vld  output  1  digit holds a decoded value
- step_pulse  output  1  one-cycle pulse on each accepted new valid digit
- dir_up  output  1  1 = last step was +1 mod MOD, 0 = -1 mod MOD
- dir_vld  output  1  dir_up meaningful
- seq_err  output  1  one-cycle pulse: accepted valid digit is neither +1 nor -1 of previous
- bad_pat  output  1  level: currently accepted pattern is not a legal code
- period  output  PW  cycles between the last two accepted valid digits
- period_vld  output  1  period meaningful

Behaviour:
- Reset (rst=1 at posedge) clears all outputs to 0, the sample register to 7'h7F, the stability count to 0, the period count to 0, and the FSM to IDLE. Reset mid-sequence discards all history.
- Legal codes (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Any other code is illegal, including codes for digits >= MOD.
- Sampling: seg_in is registered each cycle (1-cycle input latency).
  - If the sample equals the previous sample, stab_cnt increments, saturating at STABLE_CYC.
  - Otherwise stab_cnt resets to 1.
- Acceptance: occurs in the cycle stab_cnt reaches STABLE_CYC and the sample differs from the accepted pattern. A held pattern is accepted once only.
  - Total latency from a seg_in change to outputs = STABLE_CYC+1 cycles.
- Illegal pattern accepted: bad_pat=1. digit, digit_vld, dir, period and FSM state are unchanged. bad_pat clears on the next legal acceptance.
- FSM states:
  - IDLE: no valid digit yet. First legal acceptance -> LOCKED: digit loaded, digit_vld=1, step_pulse=1, period count restarts at 1.
  - LOCKED: one reference digit. Next legal acceptance -> TRACKING. Load dir_up/dir_vld, or pulse seq_err (dir_vld stays 0). Latch period, period_vld=1.
  - TRACKING: each legal acceptance updates digit, pulses step_pulse, and latches period.
    - new == (old+1) mod MOD: dir_up=1.
    - new == (old-1) mod MOD: dir_up=0.
    - Otherwise: seq_err pulse; dir_up/dir_vld retain their values.
    - Stays in TRACKING.
- Wrap: MOD-1 -> 0 counts as up; 0 -> MOD-1 counts as down. With MOD=2, +1 and -1 coincide; up wins.
- Period counter: counts every cycle after the first valid acceptance and saturates at all-ones, never wrapping. On acceptance, period <= count and the counter reloads to 1 in the same cycle. A saturated period reports all-ones.
- Simultaneous rst and acceptance: reset wins.
- Pulses last exactly one cycle and never repeat for a held pattern.

Optional Feature:
- Macro SEG7_BLANK_EN.
- Defined: pattern 7F (all segments off) is legal "blank".
  - Acceptance clears digit_vld, dir_vld and period_vld and returns the FSM to IDLE.
  - bad_pat is not raised.
  - The period counter stops and clears.
- Undefined: 7F is an illegal pattern (bad_pat=1, no state change).

Test Plan:
- Reset, hold seg_in=40 for 4 cycles -> at cycle 5: digit=0, digit_vld=1, step_pulse one cycle, dir_vld=0, period_vld=0.
- Sequence 0,1,2 (codes 40,79,24), each held 100 cycles -> dir_up=1, dir_vld=1, period=100 after the 2nd and 3rd steps, no seq_err.
- Sequence 9 (10) then 0 (40) -> dir_up=1. Then 0 (40) then 9 (10) -> dir_up=0. No seq_err on either wrap.
- Pulse seg_in=24 for 3 cycles inside a stable 79 -> no acceptance; digit stays 1, no step_pulse. Step 1 -> 5 (12) -> seq_err pulse, digit=5, dir_up unchanged.
- Apply code 7F: without SEG7_BLANK_EN, bad_pat=1 and digit is held; with SEG7_BLANK_EN, digit_vld=0 and the FSM is in IDLE. Assert rst during TRACKING -> all outputs 0 on the next cycle.
